// File: rtl/ec_scalar_mul_if.sv
// Bundles the request/result side and the point-adder handshake of ec_scalar_mul.
// master: the scalar multiplier (initiator towards the point adder).
// slave : the environment that issues requests and hosts the point adder.
interface ec_scalar_mul_if #(
    parameter int DATA_WIDTH   = 256,
    parameter int SCALAR_WIDTH = 256
);
    logic                    in_valid;
    logic [SCALAR_WIDTH-1:0] k;
    logic [DATA_WIDTH-1:0]   Px;
    logic [DATA_WIDTH-1:0]   Py;
    logic                    busy;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   Rx;
    logic [DATA_WIDTH-1:0]   Ry;
    logic                    add_in_valid;
    logic [DATA_WIDTH-1:0]   add_Px;
    logic [DATA_WIDTH-1:0]   add_Py;
    logic [DATA_WIDTH-1:0]   add_Qx;
    logic [DATA_WIDTH-1:0]   add_Qy;
    logic                    add_out_valid;
    logic [DATA_WIDTH-1:0]   add_Rx;
    logic [DATA_WIDTH-1:0]   add_Ry;

    modport master (
        input  in_valid, k, Px, Py, add_out_valid, add_Rx, add_Ry,
        output busy, out_valid, Rx, Ry,
        output add_in_valid, add_Px, add_Py, add_Qx, add_Qy
    );

    modport slave (
        output in_valid, k, Px, Py, add_out_valid, add_Rx, add_Ry,
        input  busy, out_valid, Rx, Ry,
        input  add_in_valid, add_Px, add_Py, add_Qx, add_Qy
    );
endinterface

// File: rtl/ec_scalar_mul.sv
// ec_scalar_mul: R = k*P by left-to-right double-and-add (MSB first), driving an
// external point adder. The point at infinity is (0,0) everywhere.
// Optional build macro SCMUL_CONST_TIME_EN: every bit issues a doubling and an
// add request (results of adds for zero bits are discarded) so the transaction
// count and latency do not depend on k or P.
//
// state    | meaning
// IDLE     | waiting for in_valid
// LOAD     | operands captured, check for trivial zero result
// DBL_REQ  | issue acc+acc to the adder (or skip when acc is infinity)
// DBL_WAIT | waiting for the doubling result
// ADD_REQ  | issue P+acc to the adder (or skip / shortcut)
// ADD_WAIT | waiting for the add result
// NEXT     | advance to the next lower scalar bit
// DONE     | result presented with out_valid for one cycle
module ec_scalar_mul #(
    parameter int DATA_WIDTH   = 256,
    parameter int SCALAR_WIDTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    ec_scalar_mul_if.master bus
);
    localparam int IDX_W = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SCALAR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [SCALAR_WIDTH-1:0] k_q, k_d;
    logic [DATA_WIDTH-1:0]   px_q, px_d, py_q, py_d;
    logic [DATA_WIDTH-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d, ry_q, ry_d;
    logic                    out_valid_q, out_valid_d;
    logic                    add_in_valid_q, add_in_valid_d;
    logic [DATA_WIDTH-1:0]   add_px_q, add_px_d, add_py_q, add_py_d;
    logic [DATA_WIDTH-1:0]   add_qx_q, add_qx_d, add_qy_q, add_qy_d;
    logic                    k_bit;

    assign k_bit = k_q[idx_q];

`ifndef SCMUL_CONST_TIME_EN
    logic acc_zero;
    assign acc_zero = (acc_x_q == '0) && (acc_y_q == '0);
`endif

    // Next-state, datapath updates and adder request generation.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        px_d           = px_q;
        py_d           = py_q;
        acc_x_d        = acc_x_q;
        acc_y_d        = acc_y_q;
        idx_d          = idx_q;
        rx_d           = rx_q;
        ry_d           = ry_q;
        out_valid_d    = 1'b0;
        add_in_valid_d = 1'b0;
        add_px_d       = add_px_q;
        add_py_d       = add_py_q;
        add_qx_d       = add_qx_q;
        add_qy_d       = add_qy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    k_d     = bus.k;
                    px_d    = bus.Px;
                    py_d    = bus.Py;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    idx_d   = IDX_TOP;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef SCMUL_CONST_TIME_EN
                state_d = S_DBL_REQ;
`else
                if ((k_q == '0) || ((px_q == '0) && (py_q == '0))) begin
                    acc_x_d     = '0;
                    acc_y_d     = '0;
                    rx_d        = '0;
                    ry_d        = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_DBL_REQ;
                end
`endif
            end
            S_DBL_REQ: begin
`ifndef SCMUL_CONST_TIME_EN
                if (acc_zero) begin
                    state_d = S_ADD_REQ;
                end else
`endif
                begin
                    add_in_valid_d = 1'b1;
                    add_px_d       = acc_x_q;
                    add_py_d       = acc_y_q;
                    add_qx_d       = acc_x_q;
                    add_qy_d       = acc_y_q;
                    state_d        = S_DBL_WAIT;
                end
            end
            S_DBL_WAIT: begin
                if (bus.add_out_valid) begin
                    acc_x_d  = bus.add_Rx;
                    acc_y_d  = bus.add_Ry;
                    add_px_d = '0;
                    add_py_d = '0;
                    add_qx_d = '0;
                    add_qy_d = '0;
                    state_d  = S_ADD_REQ;
                end
            end
            S_ADD_REQ: begin
`ifdef SCMUL_CONST_TIME_EN
                add_in_valid_d = 1'b1;
                add_px_d       = px_q;
                add_py_d       = py_q;
                add_qx_d       = acc_x_q;
                add_qy_d       = acc_y_q;
                state_d        = S_ADD_WAIT;
`else
                if (!k_bit) begin
                    state_d = S_NEXT;
                end else if (acc_zero) begin
                    // infinity + P = P, no adder round trip needed
                    acc_x_d = px_q;
                    acc_y_d = py_q;
                    state_d = S_NEXT;
                end else begin
                    add_in_valid_d = 1'b1;
                    add_px_d       = px_q;
                    add_py_d       = py_q;
                    add_qx_d       = acc_x_q;
                    add_qy_d       = acc_y_q;
                    state_d        = S_ADD_WAIT;
                end
`endif
            end
            S_ADD_WAIT: begin
                if (bus.add_out_valid) begin
`ifdef SCMUL_CONST_TIME_EN
                    // dummy add for a zero bit: result dropped, acc kept
                    if (k_bit) begin
                        acc_x_d = bus.add_Rx;
                        acc_y_d = bus.add_Ry;
                    end
`else
                    acc_x_d = bus.add_Rx;
                    acc_y_d = bus.add_Ry;
`endif
                    add_px_d = '0;
                    add_py_d = '0;
                    add_qx_d = '0;
                    add_qy_d = '0;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    rx_d        = acc_x_q;
                    ry_d        = acc_y_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_DBL_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            px_q           <= '0;
            py_q           <= '0;
            acc_x_q        <= '0;
            acc_y_q        <= '0;
            idx_q          <= '0;
            rx_q           <= '0;
            ry_q           <= '0;
            out_valid_q    <= 1'b0;
            add_in_valid_q <= 1'b0;
            add_px_q       <= '0;
            add_py_q       <= '0;
            add_qx_q       <= '0;
            add_qy_q       <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            px_q           <= px_d;
            py_q           <= py_d;
            acc_x_q        <= acc_x_d;
            acc_y_q        <= acc_y_d;
            idx_q          <= idx_d;
            rx_q           <= rx_d;
            ry_q           <= ry_d;
            out_valid_q    <= out_valid_d;
            add_in_valid_q <= add_in_valid_d;
            add_px_q       <= add_px_d;
            add_py_q       <= add_py_d;
            add_qx_q       <= add_qx_d;
            add_qy_q       <= add_qy_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.Rx           = rx_q;
    assign bus.Ry           = ry_q;
    assign bus.add_in_valid = add_in_valid_q;
    assign bus.add_Px       = add_px_q;
    assign bus.add_Py       = add_py_q;
    assign bus.add_Qx       = add_qx_q;
    assign bus.add_Qy       = add_qy_q;
endmodule

// File: tb/tb_ec_scalar_mul.sv
// Bench for ec_scalar_mul. The point adder here is a stand-in group: points add
// componentwise modulo the secp192k1 prime, with (0,0) as identity. In that group
// k*P is simply (k*Px mod p, k*Py mod p), which the reference computes directly.
module tb_ec_scalar_mul;
    localparam int DW = 256;
    localparam int SW = 256;
    localparam int LIMIT = 40000;
    localparam logic [255:0] P_MOD = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFEE37;
    localparam logic [255:0] GX    = 256'hDB4FF10E_C057E9AE_26B07D02_80B7F434_1DA5D1B1_EAE06C7D;
    localparam logic [255:0] GY    = 256'h9B2F2F6D_9C5628A7_844163D0_15BE8634_4082AA88_D95E2F9D;

    typedef struct {
        logic [255:0] px, py, qx, qy;
    } txn_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   txn_count = 0;
    int   stab_err = 0;
    int   overlap_err = 0;
    int   idle_err = 0;
    int   lat_lo = 3;
    int   lat_hi = 8;
    bit   pending = 0;
    int   last_cyc;
    int   last_base;
    txn_t log_q[$];

    ec_scalar_mul_if #(.DATA_WIDTH(DW), .SCALAR_WIDTH(SW)) bus ();

    ec_scalar_mul #(.DATA_WIDTH(DW), .SCALAR_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rnd256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [255:0] rnd_coord();
        logic [255:0] r;
        r = {64'd0, rnd256()[191:0]} % P_MOD;
        if (r == '0) r = 256'd1;
        return r;
    endfunction

    function automatic logic [255:0] smul(input logic [255:0] kk, input logic [255:0] v);
        logic [511:0] t;
        t = ({256'd0, kk} * {256'd0, v}) % {256'd0, P_MOD};
        return t[255:0];
    endfunction

    function automatic int exp_txn(input logic [255:0] kk, input logic [255:0] px,
                                   input logic [255:0] py);
`ifdef SCMUL_CONST_TIME_EN
        return 2 * SW + 0 * int'(kk[0] ^ px[0] ^ py[0]);
`else
        int msb;
        int pc;
        msb = -1;
        pc  = 0;
        if (kk == '0 || (px == '0 && py == '0)) return 0;
        for (int i = 0; i < SW; i++) begin
            if (kk[i]) begin
                msb = i;
                pc++;
            end
        end
        // top set bit loads P for free; every lower bit doubles; other set bits add
        return msb + pc - 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Adder model: random latency, checks operand stability, single outstanding request
    // and zero operands between transactions; returns garbage when not valid.
    initial begin
        int   cnt;
        txn_t cur;
        cnt = 0;
        bus.add_out_valid = 1'b0;
        bus.add_Rx = '0;
        bus.add_Ry = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.add_out_valid = 1'b0;
            bus.add_Rx = rnd256();
            bus.add_Ry = rnd256();
            if (rst) begin
                pending = 0;
            end else if (bus.add_in_valid) begin
                if (pending) overlap_err++;
                cur.px = bus.add_Px;
                cur.py = bus.add_Py;
                cur.qx = bus.add_Qx;
                cur.qy = bus.add_Qy;
                log_q.push_back(cur);
                txn_count++;
                pending = 1;
                cnt = $urandom_range(lat_hi, lat_lo);
            end else if (pending) begin
                if (bus.add_Px !== cur.px || bus.add_Py !== cur.py ||
                    bus.add_Qx !== cur.qx || bus.add_Qy !== cur.qy) stab_err++;
                cnt--;
                if (cnt == 0) begin
                    bus.add_out_valid = 1'b1;
                    bus.add_Rx = ({1'b0, cur.px} + {1'b0, cur.qx}) % {1'b0, P_MOD};
                    bus.add_Ry = ({1'b0, cur.py} + {1'b0, cur.qy}) % {1'b0, P_MOD};
                    pending = 0;
                end
            end else if ((bus.add_Px | bus.add_Py | bus.add_Qx | bus.add_Qy) !== '0) begin
                idle_err++;
            end
        end
    end

    task automatic run_op(input string tag, input logic [255:0] kk, input logic [255:0] px,
                          input logic [255:0] py, input int lo, input int hi, input bit inject);
        logic [255:0] ex, ey;
        int base, se, oe, ie, cyc;
        ex = smul(kk, px);
        ey = smul(kk, py);
        lat_lo = lo;
        lat_hi = hi;
        base = txn_count;
        se = stab_err;
        oe = overlap_err;
        ie = idle_err;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.k  = kk;
        bus.Px = px;
        bus.Py = py;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, ".busy"}, bus.busy, 1);
        cyc = 1;
        while (!bus.out_valid && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && cyc == 5) begin
                bus.in_valid = 1'b1;
                bus.k  = rnd256();
                bus.Px = rnd_coord();
                bus.Py = rnd_coord();
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        last_cyc  = cyc;
        last_base = base;
        check({tag, ".out_valid"}, bus.out_valid, 1);
        check({tag, ".Rx"}, bus.Rx, ex);
        check({tag, ".Ry"}, bus.Ry, ey);
        check({tag, ".ntxn"}, txn_count - base, exp_txn(kk, px, py));
        check({tag, ".stable"}, stab_err - se, 0);
        check({tag, ".overlap"}, overlap_err - oe, 0);
        check({tag, ".idle_ops"}, idle_err - ie, 0);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {bus.out_valid, bus.busy}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".hold"}, {bus.Rx, bus.Ry}, {ex, ey});
    endtask

    initial begin
        logic [255:0] kk, px, py;
        int w;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.k  = '0;
        bus.Px = '0;
        bus.Py = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctl", {bus.busy, bus.out_valid, bus.add_in_valid}, 3'b000);
        check("reset.R", {bus.Rx, bus.Ry}, 512'd0);
        check("reset.ops", bus.add_Px | bus.add_Py | bus.add_Qx | bus.add_Qy, 0);
        rst = 1'b0;

        run_op("k1", 256'd1, GX, GY, 3, 8, 0);

        run_op("k2", 256'd2, GX, GY, 3, 8, 0);
`ifndef SCMUL_CONST_TIME_EN
        check("k2.op0", {log_q[last_base].px, log_q[last_base].py,
                         log_q[last_base].qx, log_q[last_base].qy}, {GX, GY, GX, GY});
`endif

        run_op("k3", 256'd3, GX, GY, 3, 8, 0);
`ifndef SCMUL_CONST_TIME_EN
        check("k3.op0", {log_q[last_base].px, log_q[last_base].py,
                         log_q[last_base].qx, log_q[last_base].qy}, {GX, GY, GX, GY});
        check("k3.op1", {log_q[last_base+1].px, log_q[last_base+1].py,
                         log_q[last_base+1].qx, log_q[last_base+1].qy},
              {GX, GY, smul(256'd2, GX), smul(256'd2, GY)});
`endif

        run_op("k0", 256'd0, GX, GY, 3, 8, 0);
`ifndef SCMUL_CONST_TIME_EN
        check("k0.latency", (last_cyc <= 3), 1);
`endif
        run_op("p0", 256'd5, 256'd0, 256'd0, 3, 8, 0);
`ifndef SCMUL_CONST_TIME_EN
        check("p0.latency", (last_cyc <= 3), 1);
`endif

        kk = rnd256();
        kk[255] = 1'b1;
        run_op("rnd_full", kk, rnd_coord(), rnd_coord(), 3, 8, 1);
        kk = {224'd0, 32'($urandom())};
        run_op("rnd_slow", kk, rnd_coord(), rnd_coord(), 3, 40, 1);
        run_op("rnd_any", rnd256(), rnd_coord(), rnd_coord(), 3, 8, 1);

        // reset while the first doubling is outstanding
        kk = rnd256();
        kk[255] = 1'b1;
        px = rnd_coord();
        py = rnd_coord();
        lat_lo = 20;
        lat_hi = 30;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.k  = kk;
        bus.Px = px;
        bus.Py = py;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (!pending && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("rst_mid.reached_wait", pending, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.ctl", {bus.busy, bus.out_valid, bus.add_in_valid}, 3'b000);
        check("rst_mid.R", {bus.Rx, bus.Ry}, 512'd0);
        check("rst_mid.ops", bus.add_Px | bus.add_Py | bus.add_Qx | bus.add_Qy, 0);
        rst = 1'b0;
        run_op("after_rst_k2", 256'd2, GX, GY, 3, 8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ec_scalar_mul.md
Name: ec_scalar_mul

Overview:
Computes R = k·P on the secp192k1 curve using left-to-right double-and-add, MSB first. It is the initiator side of the point-adder handshake: it drives an external point-add unit (add_in_valid, operands) and consumes its add_out_valid pulse and result. The point at infinity is encoded as (0,0) throughout, matching the adder's convention.

Parameters:
DATA_WIDTH, 256, coordinate width; must equal the adder's DATA_WIDTH.
SCALAR_WIDTH, 256, width of scalar k; the bit index counter is clog2(SCALAR_WIDTH) bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  start pulse; sampled only in IDLE
k  in  SCALAR_WIDTH  scalar
Px  in  DATA_WIDTH  base point X
Py  in  DATA_WIDTH  base point Y
busy  out  1  high from the cycle after acceptance through DONE
out_valid  out  1  one-cycle result pulse
Rx  out  DATA_WIDTH  result X, held until the next accepted request
Ry  out  DATA_WIDTH  result Y, held until the next accepted request
add_in_valid  out  1  one-cycle request pulse to the adder
add_Px  out  DATA_WIDTH  adder operand P.x
add_Py  out  DATA_WIDTH  adder operand P.y
add_Qx  out  DATA_WIDTH  adder operand Q.x
add_Qy  out  DATA_WIDTH  adder operand Q.y
add_out_valid  in  1  adder completion pulse
add_Rx  in  DATA_WIDTH  adder result X; valid only while add_out_valid is high
add_Ry  in  DATA_WIDTH  adder result Y; valid only while add_out_valid is high

Behaviour:
- Fixed decision: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs are 0, FSM is in IDLE, acc = (0,0), idx = 0, captured operands are 0.
- Registered state: k_reg, Px_reg, Py_reg, accumulator (acc_x, acc_y), idx.
- FSM states: IDLE, LOAD, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE.
- IDLE:
  - On in_valid, capture k, Px, Py; set acc = (0,0) and idx = SCALAR_WIDTH-1; go to LOAD.
  - in_valid outside IDLE is ignored.
- LOAD: if k_reg == 0 or (Px_reg,Py_reg) == (0,0), go to DONE with acc = (0,0). Otherwise go to DBL_REQ.
- DBL_REQ:
  - If acc == (0,0), skip the doubling and go to ADD_REQ.
  - Otherwise pulse add_in_valid for one cycle with P = Q = acc, then go to DBL_WAIT.
- DBL_WAIT: on add_out_valid, acc <= add_R; go to ADD_REQ.
- ADD_REQ:
  - If k_reg[idx] == 0, go to NEXT.
  - Else if acc == (0,0), acc <= (Px_reg,Py_reg) with no adder request; go to NEXT.
  - Else pulse add_in_valid with P = (Px_reg,Py_reg), Q = acc; go to ADD_WAIT.
- ADD_WAIT: on add_out_valid, acc <= add_R; go to NEXT. A (0,0) result (P + (−P)) is a legal accumulator value.
- NEXT: if idx == 0 go to DONE; else idx <= idx-1 and go to DBL_REQ.
- DONE: Rx/Ry <= acc; out_valid = 1 for exactly one cycle; return to IDLE.
- Adder operand rules:
  - add_P* and add_Q* are registered.
  - They are stable from the add_in_valid cycle through the add_out_valid cycle, because the adder samples them over several cycles.
  - They are 0 outside transactions.
- At most one adder transaction is outstanding at a time. add_in_valid is never asserted while waiting on add_out_valid.
- add_out_valid arriving outside DBL_WAIT/ADD_WAIT is ignored.
- busy = 1 in every state except IDLE.
- Reset mid-operation: FSM returns to IDLE and add_in_valid = 0 the next cycle. The adder shares rst, so no orphan transaction remains.
- Worst-case latency: SCALAR_WIDTH × (2 × adder latency + 4) + 3 cycles.

Optional Feature:
Macro: SCMUL_CONST_TIME_EN.
- Defined: no skips.
  - Every bit issues a doubling request, including when acc == (0,0); the adder returns (0,0).
  - Every bit issues an add request; when k_reg[idx] == 0 the result is discarded and acc is unchanged.
  - The ADD_REQ infinity shortcut is removed; the adder's Q == (0,0) case returns P.
  - The LOAD zero checks are removed.
  - Transaction count is always 2·SCALAR_WIDTH and latency is data-independent.
- Undefined: skip rules as specified in Behaviour.

Test Plan:
- k=1, P=G (secp192k1 generator) -> 0 add_in_valid pulses; R=G; out_valid one cycle; Rx/Ry held afterwards.
- k=2, P=G -> exactly 1 transaction with add_P = add_Q = G; R equals the adder model's result.
- k=3, P=G -> 2 transactions (double with P=Q=G, then add with P=G, Q=2G); R=3G per golden model.
- k=0 and, separately, P=(0,0) with k=5 -> 0 transactions; R=(0,0) within 3 cycles of in_valid.
- Adder model with random 3–40 cycle latency, in_valid asserted while busy -> second request ignored; operands stable across each transaction; single outstanding request.
- rst asserted in DBL_WAIT -> next cycle all outputs 0, FSM in IDLE; a new k=2 request completes correctly. With SCMUL_CONST_TIME_EN defined, k=1 -> 2·SCALAR_WIDTH transactions and R=G.
